spi_child_rx: RTL

SPI child-side receiver for the 250 kHz parent link (CPOL 0, CPHA 1, MSB first). It oversamples SCL/SS/MOSI in the 50 MHz `clk` domain and collects two SS-framed bytes: byte0 = 4 zero pad bits + D[11:8], byte1 = D[7:0]. It then presents the 12-bit word on a valid/ready interface. It sits on the receiving FPGA opposite the SPI parent transmitter.

---
 rtl/spi_child_pkg.sv | 25 ++
 rtl/spi_child_rx_if.sv | 21 ++
 rtl/spi_child_sync.sv | 35 +++
 rtl/spi_child_rx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/spi_child_pkg.sv
// Shared types and constants for the SPI child receiver: FSM states, word/byte
// geometry and the two-byte word assembly helper.
package spi_child_pkg;

  localparam int WORD_W        = 12;
  localparam int BYTE_W        = 8;
  localparam int PAD_W         = 4;
  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    GAP,
    BYTE1
  } state_t;

  // Word = low nibble of byte0 (D[11:8]) followed by byte1 (D[7:0]).
  function automatic logic [WORD_W-1:0] assemble_word(
    input logic [WORD_W-BYTE_W-1:0] hi,
    input logic [BYTE_W-1:0]        lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/spi_child_rx_if.sv
// Valid/ready word handshake between the SPI child receiver (master side)
// and its consumer (slave side), plus the error/overrun status pulses.
interface spi_child_rx_if;
  import spi_child_pkg::*;

  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_err;
  logic              rx_overrun;

  modport master (
    output rx_data, rx_valid, rx_err, rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_err, rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/spi_child_sync.sv
// STAGES-deep synchronizer for one SPI pin, with registered single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_child_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  assign level = chain[STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/spi_child_rx.sv
// SPI child receiver (CPOL 0, CPHA 1, MSB first): two SS-framed bytes form a
// 12-bit word on a valid/ready port. `SPI_CHILD_PAD_CHECK_EN rejects nonzero pads.
module spi_child_rx
  import spi_child_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GAP_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCL,
  input  logic              SS,
  input  logic              MOSI,
  spi_child_rx_if.master    rx,
  output logic              busy
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  logic ss_level, ss_rise, ss_fall;
  logic scl_fall, scl_rise_unused, scl_level_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_child_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .rst(rst), .din(SS),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_child_sync #(.STAGES(SYNC_STAGES)) u_sync_scl (
    .clk(clk), .rst(rst), .din(SCL),
    .level(scl_level_unused), .rise(scl_rise_unused), .fall(scl_fall)
  );

  spi_child_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(MOSI),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t                    state, state_next;
  logic [3:0]                bit_cnt;
  logic                      bit_ovf;
  logic [BYTE_W-1:0]         shift;
  logic [WORD_W-BYTE_W-1:0]  byte0_data;
  logic                      pad_bad;
  logic [GAP_W-1:0]          gap_cnt;
  logic                      latch_b0, publish, frame_err;
  logic                      byte_ok, in_byte;

  assign byte_ok = !bit_ovf && (bit_cnt == 4'(BITS_PER_BYTE));
  assign in_byte = (state == BYTE0) || (state == BYTE1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    latch_b0   = 1'b0;
    publish    = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      IDLE:  if (ss_fall) state_next = BYTE0;
      BYTE0: if (ss_rise) begin
        state_next = IDLE;
        if (byte_ok) begin
          latch_b0   = 1'b1;
          state_next = GAP;
        end else if (bit_ovf || bit_cnt != 4'd0) begin
          frame_err = 1'b1;
        end
      end
      GAP: begin
        if (ss_fall) begin
          state_next = BYTE1;
        end else if (gap_cnt == GAP_W'(GAP_TIMEOUT - 1)) begin
          frame_err  = 1'b1;
          state_next = IDLE;
        end
      end
      BYTE1: if (ss_rise) begin
        state_next = IDLE;
        if (byte_ok && !pad_bad) publish   = 1'b1;
        else                     frame_err = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit counter saturates at one byte; any further SCL fall in the same
  // select window sets a sticky overflow that is judged at SS rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      bit_ovf    <= 1'b0;
      shift      <= '0;
      byte0_data <= '0;
      gap_cnt    <= '0;
    end else begin
      if (ss_fall) begin
        bit_cnt <= '0;
        bit_ovf <= 1'b0;
      end else if (scl_fall && !ss_level && in_byte) begin
        if (bit_cnt == 4'(BITS_PER_BYTE)) bit_ovf <= 1'b1;
        else                              bit_cnt <= bit_cnt + 4'd1;
        shift <= {shift[BYTE_W-2:0], mosi_level};
      end
      if (latch_b0)           byte0_data <= shift[WORD_W-BYTE_W-1:0];
      if (latch_b0)           gap_cnt    <= '0;
      else if (state == GAP)  gap_cnt    <= gap_cnt + 1'b1;
    end
  end

`ifdef SPI_CHILD_PAD_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          pad_bad <= 1'b0;
    else if (latch_b0) pad_bad <= |shift[BYTE_W-1:BYTE_W-PAD_W];
  end
`else
  assign pad_bad = 1'b0;
`endif

  // A publish while the held word is being consumed replaces it seamlessly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.rx_err     <= 1'b0;
      rx.rx_overrun <= 1'b0;
    end else begin
      rx.rx_err     <= frame_err;
      rx.rx_overrun <= 1'b0;
      if (publish) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data  <= assemble_word(byte0_data, shift);
          rx.rx_valid <= 1'b1;
        end else begin
          rx.rx_overrun <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule
